// File: rtl/seg7_disp_mux.sv
// Four-digit, time-multiplexed seven-segment driver for a common-anode display.
// The digit values are captured once per refresh frame, so a digit never
// changes partway through a scan. Each digit is then decoded to active-low
// segments, with optional leading-zero blanking. All outputs are registered.
module seg7_disp_mux #(
  parameter int N = 18  // refresh counter width; frame = 2^N cycles, slot = 2^(N-2)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_en,
  input  logic       blank_en,
  input  logic       hold,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam logic [N-1:0] CNT_MAX = '1;

  logic [N-1:0] cnt;
  logic [1:0]   sel;
  logic         frame_end;

  // Snapshot of the digits and decimal points shown during the current frame.
  logic [3:0] s0, s1, s2, s3;
  logic [3:0] sdp;

  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       lead3, lead2, lead1;
  logic       blank_slot;
  logic [3:0] an_nxt;
  logic [7:0] sseg_nxt;

  assign sel       = cnt[N-1:N-2];
  assign frame_end = (cnt == CNT_MAX);

  // Hex to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Refresh counter and per-frame snapshot; the load happens in the last cycle
  // of a frame, so the new values appear from the first slot of the next frame.
  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      s0  <= 4'h0;
      s1  <= 4'h0;
      s2  <= 4'h0;
      s3  <= 4'h0;
      sdp <= 4'h0;
    end else begin
      cnt <= cnt + N'(1);
      if (frame_end && !hold) begin
        s0  <= d0;
        s1  <= d1;
        s2  <= d2;
        s3  <= d3;
        sdp <= dp_en;
      end
    end
  end

  // Select the digit for the current slot and work out whether it is blanked.
  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    cur_digit  = s0;
    cur_dp     = sdp[sel];
    blank_slot = 1'b0;
    lead3      = (s3 == 4'h0);
    lead2      = lead3 && (s2 == 4'h0);
    lead1      = lead2 && (s1 == 4'h0);
    case (sel)
      2'd0: cur_digit = s0;
      2'd1: begin cur_digit = s1; blank_slot = lead1; end
      2'd2: begin cur_digit = s2; blank_slot = lead2; end
      default: begin cur_digit = s3; blank_slot = lead3; end
    endcase
    // blank_en is applied live, not taken from the snapshot.
    blank_slot = blank_slot && blank_en;
    if (blank_slot) begin
      an_nxt   = 4'hF;
      sseg_nxt = 8'hFF;
    end else begin
      an_nxt   = ~(4'b0001 << sel);
      sseg_nxt = {~cur_dp, seg_decode(cur_digit)};
    end
  end

  // Output registers: glitch-free anodes/segments, one cycle behind cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= 4'hF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_disp_mux.sv
// Self-checking bench for seg7_disp_mux (N = 4). A reference model predicts the
// output of each clock edge into a queue; an independent monitor pops and
// compares on the falling edge.
module tb_seg7_disp_mux;

  localparam int N     = 4;
  localparam int FRAME = 1 << N;
  localparam int SLOT  = FRAME / 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0] dp_en = '0;
  logic       blank_en = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  seg7_disp_mux #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .dp_en      (dp_en),
    .blank_en   (blank_en),
    .hold       (hold),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Active-low segment patterns {g..a} for hex 0..F.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: cycle position in the frame plus the shown digits.
  int         m_cnt = 0;
  logic [3:0] m_snap [4];
  logic [3:0] m_sdp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Model: at each edge, predict the outputs that edge produces, then advance.
  initial begin
    exp_t e;
    int   slot;
    bit   blanked;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        e.an = 4'hF; e.sseg = 8'hFF; e.ft = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 4'h0;
        m_sdp = 4'h0;
      end else begin
        slot = m_cnt / SLOT;
        // A digit is a leading zero if it and every more significant digit is 0.
        blanked = blank_en && (slot > 0);
        for (int j = 0; j < 4; j++)
          if (j >= slot && m_snap[j] != 4'h0) blanked = 1'b0;
        if (blanked) begin
          e.an = 4'hF; e.sseg = 8'hFF;
        end else begin
          e.an   = 4'hF;
          e.an[slot] = 1'b0;
          e.sseg = {~m_sdp[slot], seg_tab[m_snap[slot]]};
        end
        e.ft = (m_cnt == FRAME - 1);
        if (m_cnt == FRAME - 1 && !hold) begin
          m_snap[0] = d0; m_snap[1] = d1; m_snap[2] = d2; m_snap[3] = d3;
          m_sdp = dp_en;
        end
        m_cnt = (m_cnt + 1) % FRAME;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("sseg", 32'(sseg), 32'(e.sseg));
        check("frame_tick", 32'(frame_tick), 32'(e.ft));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until the model's counter (the DUT's current cnt) equals k.
  task automatic align(input int k);
    int guard = 0;
    while (m_cnt != k && guard < 2 * FRAME) begin
      cycles(1);
      guard++;
    end
    check("align", 32'(m_cnt), 32'(k));
  endtask

  initial begin
    // Reset held for three edges, then a frame and a bit of zero snapshot.
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(FRAME + 4);

    // Decode/scan: 1,2,3,4 with dp on digit2.
    {d3, d2, d1, d0} = 16'h1234;
    dp_en = 4'b0100;
    cycles(3 * FRAME);

    // Hex sweep on digit0, one value per frame.
    dp_en = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      align(4);
      d0 = 4'(v);
      cycles(FRAME);
    end

    // Leading-zero blanking, then the same digits unblanked.
    {d3, d2, d1, d0} = 16'h0070;
    blank_en = 1'b1;
    cycles(2 * FRAME + 4);
    blank_en = 1'b0;
    cycles(2 * FRAME);

    // Hold/tearing: mid-frame change, first without then with hold.
    d0 = 4'h5;
    cycles(2 * FRAME);
    align(6);
    d0 = 4'h9;
    cycles(2 * FRAME);
    d0 = 4'h5;
    cycles(2 * FRAME);
    hold = 1'b1;
    align(6);
    d0 = 4'h9;
    cycles(3 * FRAME);
    align(8);
    hold = 1'b0;
    cycles(2 * FRAME);

    // Reset during the digit2 slot.
    {d3, d2, d1, d0} = 16'h4321;
    cycles(2 * FRAME);
    align(10);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(2 * FRAME);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d0 = 4'($urandom); d1 = 4'($urandom);
        d2 = 4'($urandom); d3 = 4'($urandom);
        // Bias toward zeros so blanking paths are exercised.
        if ($urandom_range(0, 1) == 0) d3 = 4'h0;
        if ($urandom_range(0, 2) == 0) d2 = 4'h0;
        dp_en = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      rst_n = ($urandom_range(0, 149) != 0);
      cycles(1);
    end
    rst_n = 1'b1;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_disp_mux.md
# seg7_disp_mux

Time-multiplexed four-digit seven-segment driver that consumes the stopwatch's BCD/hex digit outputs `d3..d0` and drives a common-anode display. It snapshots the four digits once per refresh frame so a digit never changes mid-scan. It scans one digit at a time, decodes to active-low segments, and optionally blanks leading zeros. It sits directly downstream of `stop_watch_if` at the top level.

## Interface
- `N`, 18, refresh counter width (N ≥ 2); frame = 2^N cycles, one digit slot = 2^(N-2) cycles
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `d0`..`d3`  in  4 each  digit values from the stopwatch (d0 = least significant)
- `dp_en`  in  4  decimal-point enable per digit (bit i → digit i), active high
- `blank_en`  in  1  1 = suppress leading zeros
- `hold`  in  1  1 = freeze the displayed snapshot
- `an`  out  4  anode enables, active low, bit i → digit i
- `sseg`  out  8  segments, active low; bit0 = a … bit6 = g, bit7 = dp
- `frame_tick`  out  1  one-cycle pulse at each frame start

## Operation
- Refresh counter `cnt[N-1:0]` increments every cycle and wraps 2^N-1 → 0. `sel = cnt[N-1:N-2]`.
- Slot map: sel 0 → digit0, `an`=1110; sel 1 → digit1, 1101; sel 2 → digit2, 1011; sel 3 → digit3, 0111.
- Snapshot registers `s0..s3` and `sdp` are loaded from `d0..d3` and `dp_en` in the cycle where `cnt == 2^N-1` and `hold == 0`.
  - With `hold == 1` the snapshot is unchanged.
  - Inputs never affect the display except through the snapshot.
- Decode of `sseg[6:0]`, hex:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- `sseg[7] = ~sdp[sel]`.
- Leading-zero blanking applies only when `blank_en == 1`, evaluated on the snapshot:
  - digit3 blanked if s3 == 0
  - digit2 blanked if s3 == s2 == 0
  - digit1 blanked if s3 == s2 == s1 == 0
  - digit0 is never blanked
- A blanked slot drives `an` = 1111 and `sseg` = FF; blanking also suppresses the dp.
- `blank_en` is sampled live, not snapshotted.

## Timing
- Reset (synchronous, `rst_n == 0` at a rising edge) sets:
  - `cnt` = 0
  - `s0..s3` = 0, `sdp` = 0
  - `an` = 1111, `sseg` = FF, `frame_tick` = 0
- Reset mid-scan takes effect at the next edge; the scan restarts at digit0 with a zero snapshot.
- `an`, `sseg` and `frame_tick` are registered, so the outputs lag `cnt` by 1 cycle.
  - Slot for sel k is visible on outputs from cycle (k·2^(N-2) + 1) through ((k+1)·2^(N-2)) of the frame, counted mod 2^N.
  - `an` changes only at slot boundaries; there is never more than one anode low.
- `frame_tick` is high in the cycle where `cnt == 0`, i.e. registered from `cnt == 2^N-1`. It is not asserted in the first cycle after reset.
- Snapshot latency:
  - Input change at cycle t is shown from the first frame whose start follows the next `cnt == 2^N-1` with `hold == 0`.
  - Worst-case latency is 2^N + 1 cycles to the first output slot of that frame.
- `hold` asserted in the load cycle blocks that load. Deasserting `hold` takes effect at the next frame boundary.
- A `dp_en` or `d*` change in the load cycle itself is captured (sampled at that edge).

## Test plan
All scenarios use N = 4: 16-cycle frame, 4 cycles per slot.
- **Reset:** hold `rst_n` = 0 for 3 cycles, then release → during reset `an` = 1111, `sseg` = FF, `frame_tick` = 0. After release with `blank_en` = 0: digit0 shows 0 (`an` = 1110, `sseg` = C0) in output cycles 1–4, then digits 1, 2, 3 in turn. `frame_tick` first pulses 16 cycles after release.
- **Decode/scan:** d3..d0 = 1,2,3,4 with `dp_en` = 0100 → next frame shows:
  - `an` 1110 / `sseg` 99
  - `an` 1101 / `sseg` B0
  - `an` 1011 / `sseg` 24 (dp on)
  - `an` 0111 / `sseg` F9
- **Hex sweep:** step d0 through 0–F, one value per frame → digit0 `sseg[6:0]` matches the decode list for all 16 values.
- **Blanking:** d3..d0 = 0,0,7,0 with `blank_en` = 1 → digit3 slot `an` = 1111 / `sseg` FF; digit2 blanked; digit1 = F8; digit0 = C0. With `blank_en` = 0 → all four digits lit.
- **Hold/tearing:** change d0 from 5 to 9 mid-frame, once with `hold` = 0 and once with `hold` = 1 → 9 appears only from the next frame start, and never while `hold` = 1. After `hold` drops, 9 appears one frame boundary later.
- **Reset mid-scan:** assert `rst_n` = 0 during the digit2 slot → the next edge gives `an` = 1111, `sseg` = FF; the scan resumes at digit0 with a zero snapshot.
